// File: rtl/cpu_run_sequencer.sv
// ============================================================================
// cpu_run_sequencer : queues host start addresses and launches/timed CPU runs
// Optional watchdog abort enabled by defining CPU_WATCHDOG_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module cpu_run_sequencer #(
  parameter int ADDR_W  = 8,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1000
) (
  input  logic              clock_i,
  input  logic              reset_n_i,
  input  logic              req_valid_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  output logic              req_ready_o,
  output logic              cpu_start_o,
  output logic [ADDR_W-1:0] cpu_start_addr_o,
  input  logic              cpu_done_i,
  output logic              cpu_reset_n_o,
  output logic              rsp_valid_o,
  output logic [ADDR_W-1:0] rsp_addr_o,
  output logic [CNT_W-1:0]  rsp_cycles_o,
  output logic              rsp_timeout_o,
  output logic              busy_o
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (TIMEOUT < 3)) begin : g_param_check
    $error("cpu_run_sequencer: DEPTH must be a power of 2 >= 2 and TIMEOUT >= 3");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_ARM    = 3'd2,
    S_RUN    = 3'd3,
    S_REPORT = 3'd4
`ifdef CPU_WATCHDOG_EN
    , S_ABORT = 3'd5
`endif
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]     count_q, count_d;
  logic               ready_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc, rsp_cyc_d;
  logic [ADDR_W-1:0]  addr_q, rsp_addr_q;
  logic [CNT_W-1:0]   rsp_cycles_q;
  logic               rsp_load;
  logic               push, pop;

  assign push    = req_valid_i & ready_q;
  assign pop     = (state_q == S_IDLE) && (count_q != '0);
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    unique case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

`ifdef CPU_WATCHDOG_EN
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  logic rsp_to, rsp_timeout_q;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rsp_load  = 1'b0;
    rsp_cyc_d = cnt_q;
`ifdef CPU_WATCHDOG_EN
    rsp_to    = 1'b0;
`endif
    case (state_q)
      S_IDLE:   if (count_q != '0) state_d = S_LAUNCH;
      S_LAUNCH: begin
        state_d = S_ARM;
        cnt_d   = CNT_W'(1);
      end
      // done is not looked at in ARM: the previous run may still hold it high
      S_ARM: begin
        state_d = S_RUN;
        cnt_d   = cnt_inc;
      end
      S_RUN: begin
        cnt_d = cnt_inc;
        if (cpu_done_i) begin
          state_d   = S_REPORT;
          rsp_load  = 1'b1;
          rsp_cyc_d = cnt_inc;
        end
`ifdef CPU_WATCHDOG_EN
        else if (cnt_q == TIMEOUT_C) begin
          state_d = S_ABORT;
          cnt_d   = cnt_q;
        end
`endif
      end
`ifdef CPU_WATCHDOG_EN
      S_ABORT: begin
        state_d   = S_REPORT;
        rsp_load  = 1'b1;
        rsp_to    = 1'b1;
        rsp_cyc_d = cnt_q;
      end
`endif
      S_REPORT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (push) mem_q[wr_ptr_q] <= req_addr_i;
  end

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      ready_q      <= 1'b1;
      cnt_q        <= '0;
      addr_q       <= '0;
      rsp_addr_q   <= '0;
      rsp_cycles_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ready_q <= (count_d != FULL_CNT);
      cnt_q   <= cnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        addr_q   <= mem_q[rd_ptr_q];
      end
      if (rsp_load) begin
        rsp_addr_q   <= addr_q;
        rsp_cycles_q <= rsp_cyc_d;
      end
    end
  end

`ifdef CPU_WATCHDOG_EN
  always_ff @(posedge clock_i) begin
    if (!reset_n_i)    rsp_timeout_q <= 1'b0;
    else if (rsp_load) rsp_timeout_q <= rsp_to;
  end

  assign cpu_reset_n_o = (state_q != S_ABORT);
  assign rsp_timeout_o = rsp_timeout_q;
`else
  assign cpu_reset_n_o = 1'b1;
  assign rsp_timeout_o = 1'b0;
`endif

  assign req_ready_o      = ready_q;
  assign cpu_start_o      = (state_q == S_LAUNCH);
  assign cpu_start_addr_o = addr_q;
  assign rsp_valid_o      = (state_q == S_REPORT);
  assign rsp_addr_o       = rsp_addr_q;
  assign rsp_cycles_o     = rsp_cycles_q;
  assign busy_o           = (state_q != S_IDLE) || (count_q != '0);

endmodule

`default_nettype wire

// File: tb/tb_cpu_run_sequencer.sv
// ============================================================================
// tb_cpu_run_sequencer : scoreboard bench for cpu_run_sequencer  Rev 1.0
// ============================================================================
`default_nettype none

module tb_cpu_run_sequencer;
  localparam int ADDR_W  = 8;
  localparam int DEPTH   = 4;
  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 50;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic              req_ready;
  logic              cpu_start;
  logic [ADDR_W-1:0] cpu_start_addr;
  logic              cpu_done;
  logic              cpu_reset_n;
  logic              rsp_valid;
  logic [ADDR_W-1:0] rsp_addr;
  logic [CNT_W-1:0]  rsp_cycles;
  logic              rsp_timeout;
  logic              busy;

  always #5 clk = ~clk;

  cpu_run_sequencer #(
    .ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock_i(clk), .reset_n_i(rst_n),
    .req_valid_i(req_valid), .req_addr_i(req_addr), .req_ready_o(req_ready),
    .cpu_start_o(cpu_start), .cpu_start_addr_o(cpu_start_addr),
    .cpu_done_i(cpu_done), .cpu_reset_n_o(cpu_reset_n),
    .rsp_valid_o(rsp_valid), .rsp_addr_o(rsp_addr), .rsp_cycles_o(rsp_cycles),
    .rsp_timeout_o(rsp_timeout), .busy_o(busy)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  cyc;
    logic              to;
  } rsp_t;

  rsp_t              exp_rsp[$];
  logic [ADDR_W-1:0] exp_start[$];
  int                total = 0;
  int                bad = 0;
  int                aborts = 0;
  int                done_delay = 5;
  bit                hang = 1'b0;
  rsp_t              m_r;
  logic [ADDR_W-1:0] m_a;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: every start pulse and every response is matched against the queues
  always @(negedge clk) begin
    if (rst_n) begin
      if (cpu_start) begin
        if (exp_start.size() == 0) chk("unexpected_start", 32'(cpu_start), 0);
        else begin
          m_a = exp_start.pop_front();
          chk("start_addr", 32'(cpu_start_addr), 32'(m_a));
        end
      end
      if (rsp_valid) begin
        if (exp_rsp.size() == 0) chk("unexpected_rsp", 32'(rsp_valid), 0);
        else begin
          m_r = exp_rsp.pop_front();
          chk("rsp_addr", 32'(rsp_addr), 32'(m_r.addr));
          chk("rsp_cycles", 32'(rsp_cycles), 32'(m_r.cyc));
          chk("rsp_timeout", 32'(rsp_timeout), 32'(m_r.to));
          chk("start_addr_held", 32'(cpu_start_addr), 32'(m_r.addr));
        end
      end
      if (!cpu_reset_n) aborts++;
    end
  end

  // CPU model: done stays high after a run (stale through ARM), drops in first
  // RUN cycle and rises in cycle start+done_delay, unless the CPU hangs.
  initial begin
    cpu_done = 1'b0;
    forever begin
      @(negedge clk);
      if (cpu_start && rst_n) begin
        if (hang) begin
          @(posedge clk);
          @(posedge clk);
          #1 cpu_done = 1'b0;
        end else begin
          for (int k = 1; k <= done_delay; k++) begin
            @(posedge clk);
            #1;
            if (k == 2) cpu_done = 1'b0;
          end
          cpu_done = 1'b1;
        end
      end
    end
  end

  task automatic push(input logic [ADDR_W-1:0] a, input bit exp_acc, input bit track);
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = a;
    chk("req_ready", 32'(req_ready), 32'(exp_acc));
    if (exp_acc && track) begin
      exp_start.push_back(a);
      if (!hang) exp_rsp.push_back(rsp_t'{addr: a, cyc: CNT_W'(done_delay + 1), to: 1'b0});
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while ((exp_rsp.size() != 0 || exp_start.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_within_budget", 32'(n < budget), 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 1);
    chk("rst_cpu_start", 32'(cpu_start), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cpu_reset_n", 32'(cpu_reset_n), 1);
    rst_n = 1'b1;
  endtask

  logic [ADDR_W-1:0] t4_addr [6];
  bit                t4_acc  [6];

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;

    // Reset state
    do_reset();
    chk("rst_rsp_cycles", 32'(rsp_cycles), 0);
    chk("rst_rsp_timeout", 32'(rsp_timeout), 0);

    // Single run: done in cycle start+21 -> 22 cycles; start one cycle after pop edge
    done_delay = 21;
    push(8'd0, 1'b1, 1'b1);
    @(posedge clk);
    @(negedge clk);
    chk("launch_latency", 32'(cpu_start), 1);
    wait_idle(100);

    // Three queued back-to-back runs with stale done during ARM
    done_delay = 5;
    push(8'd0, 1'b1, 1'b1);
    push(8'd93, 1'b1, 1'b1);
    push(8'd138, 1'b1, 1'b1);
    wait_idle(200);

    // Queue full with CPU stalled: 5 accepted (first pops), 6th rejected
    hang = 1'b1;
    t4_addr = '{8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15};
    t4_acc  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
`ifdef CPU_WATCHDOG_EN
      push(t4_addr[i], t4_acc[i], 1'b1);
      if (t4_acc[i]) exp_rsp.push_back(rsp_t'{addr: t4_addr[i], cyc: CNT_W'(TIMEOUT), to: 1'b1});
`else
      push(t4_addr[i], t4_acc[i], i == 0);
`endif
    end
    push(8'd16, 1'b0, 1'b0);
    @(negedge clk);
    chk("full_busy", 32'(busy), 1);
    chk("full_not_ready", 32'(req_ready), 0);

`ifdef CPU_WATCHDOG_EN
    // Every hung run is aborted with one cycle of CPU reset, then the next launches
    wait_idle(600);
    chk("abort_reset_cycles", 32'(aborts), 5);
`endif

    // Reset mid-RUN: run dropped with no response, queued entry lost
    do_reset();
    push(8'd77, 1'b1, 1'b1);
    push(8'd78, 1'b1, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("midrun_busy", 32'(busy), 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(req_ready), 1);
    chk("post_rst_busy", 32'(busy), 0);
    repeat (60) @(negedge clk);
    chk("post_rst_idle", 32'(busy), 0);

    // Minimum run: done in first RUN cycle -> 3 cycles
    hang = 1'b0;
    done_delay = 2;
    push(8'd200, 1'b1, 1'b1);
    wait_idle(50);

    chk("start_queue_empty", 32'(exp_start.size()), 0);
    chk("rsp_queue_empty", 32'(exp_rsp.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "global timeout");
  end

endmodule

`default_nettype wire
